// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the write-buffer state used by the SRAM controller.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ADDR  = 2'b01,
      PEND  = 2'b10
   } buf_state_t;

endpackage

// File: rtl/ahb_sram_bytemask.sv
// Converts an AHB transfer size and the low address bits into a 4-bit byte-lane mask.
module ahb_sram_bytemask
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] mask
);

   // Anything wider than a half-word touches the whole 32-bit SRAM word.
   always_comb begin
      mask = 4'b1111;
      case (hsize)
         HSIZE_BYTE: mask = 4'b0001 << addr_lo;
         HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    mask = 4'b1111;
      endcase
   end

endmodule

// File: rtl/ahb_sram_wbuf_ctrl.sv
// Zero-wait AHB-Lite slave for a single-port SRAM: writes are parked in a one-entry
// buffer and committed on the next cycle the port is not needed for a read.
module ahb_sram_wbuf_ctrl
   import ahb_pkg::*;
#(
   parameter int AW = 16
)
(
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic          HREADY,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HSIZE,
   input  logic          HWRITE,
   input  logic [AW-1:0] HADDR,
   input  logic [31:0]   HWDATA,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic [AW-3:0] SRAMADDR,
   output logic [3:0]    SRAMWEN,
   output logic [31:0]   SRAMWDATA,
   output logic          SRAMCS
);

   logic          req;
   logic          rd_req;
   logic          wr_req;
   logic          commit;
   logic [AW-3:0] haddr_word;
   logic [3:0]    req_mask;

   buf_state_t    state;
   logic [AW-3:0] buf_addr;
   logic [3:0]    buf_mask;
   logic [31:0]   wdata_reg;
   logic [3:0]    merge_mask;
   logic          rd_dphase;

   assign req        = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
   assign rd_req     = req & ~HWRITE;
   assign wr_req     = req & HWRITE;
   assign haddr_word = HADDR[AW-1:2];
   assign commit     = (state != EMPTY) & ~rd_req;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   ahb_sram_bytemask u_bytemask (
      .hsize   (HSIZE),
      .addr_lo (HADDR[1:0]),
      .mask    (req_mask)
   );

   // Buffer FSM; a read in ADDR forces the in-flight write data into wdata_reg so the
   // port can be given to the read while the write waits in PEND.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= EMPTY;
         buf_addr   <= '0;
         buf_mask   <= '0;
         wdata_reg  <= '0;
         merge_mask <= '0;
         rd_dphase  <= 1'b0;
      end else begin
         rd_dphase <= rd_req;
         if (rd_req)
            merge_mask <= ((state != EMPTY) && (buf_addr == haddr_word)) ? buf_mask : 4'b0000;
         else
            merge_mask <= 4'b0000;

         case (state)
            EMPTY: begin
               if (wr_req) begin
                  state    <= ADDR;
                  buf_addr <= haddr_word;
                  buf_mask <= req_mask;
               end
            end
            ADDR, PEND: begin
               if (rd_req) begin
                  if (state == ADDR)
                     wdata_reg <= HWDATA;
                  state <= PEND;
               end else if (wr_req) begin
                  state    <= ADDR;
                  buf_addr <= haddr_word;
                  buf_mask <= req_mask;
               end else begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // The read owns the port in its address phase; the SRAM pins stay quiet under reset.
   always_comb begin
      SRAMCS    = 1'b0;
      SRAMADDR  = '0;
      SRAMWEN   = 4'b0000;
      SRAMWDATA = '0;
      if (HRESETn) begin
         if (rd_req) begin
            SRAMCS   = 1'b1;
            SRAMADDR = haddr_word;
         end else if (commit) begin
            SRAMCS    = 1'b1;
            SRAMADDR  = buf_addr;
            SRAMWEN   = buf_mask;
            SRAMWDATA = (state == ADDR) ? HWDATA : wdata_reg;
         end
      end
   end

   always_comb begin
      HRDATA = '0;
      if (rd_dphase) begin
         for (int i = 0; i < 4; i++)
            HRDATA[8*i +: 8] = merge_mask[i] ? wdata_reg[8*i +: 8] : SRAMRDATA[8*i +: 8];
      end
   end

endmodule
